// File: rtl/inst_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words for the imem write port.
// Optional INST_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check reported on load_err.
`timescale 1ns/1ps
module inst_loader #(
  parameter int DEPTH = 32,
  parameter int LEN_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             RegWrite,
  output logic [31:0]      WriteReg,
  output logic [31:0]      WriteData,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_err
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CHK} state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
  logic [31:0] sum;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, word_cnt, start_len, word_inc;
  logic [1:0]       byte_cnt;
  logic [31:0]      shreg, asm_word;
  logic             accept, last_byte, start, last_word;
  logic             ready_d, hold_d, write_d, done_d;

  assign start_len = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign start     = load_start && (state == IDLE || state == DONE);
  assign accept    = byte_valid && byte_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign asm_word  = {byte_in, shreg[31:8]};
  assign word_inc  = word_cnt + 1'b1;
  assign last_word = (word_inc == len_q);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (load_start) state_n = (start_len == '0) ? END_ST : RECV;
      RECV:       if (last_byte) state_n = WRITE;
      WRITE:      state_n = last_word ? END_ST : RECV;
`ifdef INST_LOADER_CHECKSUM_EN
      CHK:        if (last_byte) state_n = DONE;
`endif
      default:    state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered with the state.
  always_comb begin
    ready_d = (state_n == RECV) || (state_n == CHK);
    hold_d  = (state_n == RECV) || (state_n == WRITE) || (state_n == CHK);
    write_d = (state_n == WRITE);
    done_d  = (state_n == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b0;
      RegWrite   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      WriteReg   <= '0;
      WriteData  <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      byte_ready <= ready_d;
      cpu_hold   <= hold_d;
      RegWrite   <= write_d;
      load_done  <= done_d;
      if (start) begin
        len_q    <= start_len;
        word_cnt <= '0;
        byte_cnt <= '0;
      end
      if (accept) begin
        shreg    <= asm_word;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (state == WRITE) word_cnt <= word_inc;
      if (write_d) begin
        WriteReg  <= 32'(word_cnt);
        WriteData <= asm_word;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      if (start) begin
        sum      <= '0;
        load_err <= 1'b0;
      end
      if (write_d) sum <= sum + asm_word;
      if (state == CHK && last_byte) load_err <= (asm_word != sum);
`endif
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: byte streams with random gaps against a word-list reference model.
`timescale 1ns/1ps
module tb_inst_loader;
  localparam int DEPTH = 32;
  localparam int LEN_W = 6;

  logic             clock = 1'b0;
  logic             reset, load_start, byte_valid;
  logic [LEN_W-1:0] load_len;
  logic [7:0]       byte_in;
  logic             byte_ready, RegWrite, cpu_hold, load_done, load_err;
  logic [31:0]      WriteReg, WriteData;

  always #5 clock = ~clock;

  inst_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  typedef struct {logic [31:0] addr; logic [31:0] data; int unsigned c;} wr_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  wr_t         got_q[$];
  int unsigned hs_q[$];
  logic [31:0] preset[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (RegWrite === 1'b1) got_q.push_back('{WriteReg, WriteData, cyc});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_RegWrite"}, RegWrite, 0);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_err"}, load_err, 0);
    check({tag, "_WriteReg"}, WriteReg, 0);
    check({tag, "_WriteData"}, WriteData, 0);
  endtask

  task automatic start_load(input int len);
    @(negedge clock);
    load_start = 1'b1;
    load_len   = LEN_W'(len);
    byte_valid = 1'b0;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Present one byte; it transfers on the posedge following a negedge that sees byte_ready.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit spur, input bit last);
    int n;
    repeat (gap) begin
      @(negedge clock);
      load_start = 1'b0;
      byte_valid = 1'b0;
    end
    @(negedge clock);
    byte_valid = 1'b1;
    byte_in    = b;
    load_start = spur;
    load_len   = LEN_W'($urandom);
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      load_start = 1'b0;
      n++;
    end
    if (byte_ready !== 1'b1) check("byte_timeout", byte_ready, 1);
    else if (last) hs_q.push_back(cyc);
  endtask

  task automatic run_load(input int len, input int gmin, input int gmax,
                          input logic [31:0] cs_delta, input string tag);
    int          n, t;
    logic [31:0] words[$];
    logic [31:0] w, sum;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [31:0] cs;
`endif
    n = (len > DEPTH) ? DEPTH : len;
    got_q.delete();
    hs_q.delete();
    sum = '0;
    start_load(len);
    for (int i = 0; i < n; i++) begin
      w = (i < preset.size()) ? preset[i] : $urandom;
      words.push_back(w);
      sum += w;
      for (int k = 0; k < 4; k++)
        send_byte(w[8*k +: 8], $urandom_range(gmax, gmin), (i > 0) && ($urandom_range(0, 7) == 0), k == 3);
    end
`ifdef INST_LOADER_CHECKSUM_EN
    cs = sum + cs_delta;
    for (int k = 0; k < 4; k++) send_byte(cs[8*k +: 8], $urandom_range(gmax, gmin), 1'b0, 1'b0);
`endif
    @(negedge clock);
    byte_valid = 1'b0;
    load_start = 1'b0;
    t = 0;
    while (load_done !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    preset.delete();
    check({tag, "_done"}, load_done, 1);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_nwr"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check({tag, "_addr"}, got_q[i].addr, i);
      check({tag, "_data"}, got_q[i].data, words[i]);
      if (i < hs_q.size()) check({tag, "_lat"}, got_q[i].c, hs_q[i] + 1);
    end
`ifdef INST_LOADER_CHECKSUM_EN
    check({tag, "_err"}, load_err, cs_delta != 0);
`else
    check({tag, "_err"}, load_err, 0);
`endif
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = '0; load_len = '0;
    repeat (3) @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clock);
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    @(negedge clock);
    byte_valid = 1'b0;
    check("idle_ready", byte_ready, 0);
    check("idle_nwr", got_q.size(), 0);
    check_idle("idle");

    preset = '{32'h0000_0013, 32'h0031_02B3};
    run_load(2, 0, 0, 32'd0, "two");
    if (got_q.size() >= 2) check("two_spacing", got_q[1].c - got_q[0].c, 5);

    preset = '{32'hDDCC_BBAA};
    run_load(1, 1, 1, 32'd0, "gappy");

    run_load(40, 0, 2, 32'd0, "clip");
    run_load(3, 0, 3, 32'd0, "restart");

    // Abort after 2 bytes of word 3; words 0..2 must be the only writes.
    got_q.delete();
    hs_q.delete();
    start_load(5);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) send_byte(8'(i * 16 + k), 0, 1'b0, k == 3);
    send_byte(8'hE0, 0, 1'b0, 1'b0);
    send_byte(8'hE1, 0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("midrst");
    repeat (10) begin
      @(negedge clock);
      byte_valid = 1'($urandom);
      byte_in    = 8'($urandom);
    end
    byte_valid = 1'b0;
    check("midrst_nwr", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      check("midrst_addr", got_q[i].addr, i);
      check("midrst_data", got_q[i].data, {8'(i * 16 + 3), 8'(i * 16 + 2), 8'(i * 16 + 1), 8'(i * 16)});
    end
    run_load(1, 0, 1, 32'd0, "postrst");

    run_load(0, 0, 1, 32'd0, "zero");

`ifdef INST_LOADER_CHECKSUM_EN
    preset = '{32'h0000_0013};
    run_load(1, 0, 0, 32'd0, "cs_ok");
    preset = '{32'h0000_0013};
    run_load(1, 0, 0, 32'd1, "cs_bad");
`endif

    for (int r = 0; r < 6; r++)
      run_load($urandom_range(45, 0), 0, 3, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(255, 1)) : 32'd0, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
